control_display_7seg: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. Holds a frame of four BCD digits plus decimal points, steps through the digits at a programmable refresh rate with an all-off guard interval between digits, and drives each digit's code through the team's BCD-to-7seg decoder. New data is double-buffered and committed only at frame boundaries, so a refresh never shows a mix of two frames. The block sits between the measurement/FSM logic and the board's anode/segment pins.

---
 rtl/display_pkg.sv | 22 ++
 rtl/decodificador_bcd_7seg.sv | 12 +
 rtl/control_display_7seg.sv | 171 +++++++++++++++++
 tb/tb_control_display_7seg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment codes are active-low, [7:1] = a..g, [0] = dp.
package display_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_ON
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // dp bit held at 1 (off); nibbles A-F blank
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,
    8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'hFF, 8'hFF,
    8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

endpackage

// File: rtl/decodificador_bcd_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// dp bit is always 1 here; the caller merges in its own dp.
module decodificador_bcd_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_code
);

  assign o_code = SEG_LUT[i_bcd];

endmodule

// File: rtl/control_display_7seg.sv
// 4-digit multiplexed 7-seg scan controller with guard interval
// and frame-boundary double buffering of the displayed value.
module control_display_7seg
  import display_pkg::*;
#(
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] valor_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anodos,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        pending
);

  localparam int MAXC = (REFRESH_DIV > GUARD_CYC) ?
                        REFRESH_DIV : GUARD_CYC;
  localparam int CW   = $clog2(MAXC);

  localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GD_LAST  = CW'(GUARD_CYC - 1);
  localparam logic [1:0]    DIG_LAST = 2'(N_DIG - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_dig;
  logic            r_bnd;

  logic [15:0]     r_sh_val;
  logic [3:0]      r_sh_dp;
  logic [15:0]     r_pd_val;
  logic [3:0]      r_pd_dp;
  logic            r_pending;

  logic [3:0]      r_anodos;
  logic [7:0]      r_seg;
  logic            r_frame_done;
  logic            r_pend_o;

  logic [3:0]      w_nib;
  logic [7:0]      w_code;
  logic            w_dp;
  logic [3:0]      w_an_on;
  logic            w_lit;
  logic            w_boundary;
  logic            w_ld_off;
  logic            w_ld_scan;

  assign w_nib      = 4'(r_sh_val >> {r_dig, 2'b00});
  assign w_dp       = r_sh_dp[r_dig];
  assign w_an_on    = ~(4'b0001 << r_dig);
  assign w_lit      = (r_state == S_ON) && enable;
  assign w_boundary = w_lit && (r_cnt == ON_LAST) &&
                      (r_dig == DIG_LAST);
  assign w_ld_off   = load && (r_state == S_OFF);
  assign w_ld_scan  = load && (r_state != S_OFF);

  decodificador_bcd_7seg u_dec (
    .i_bcd  (w_nib),
    .o_code (w_code)
  );

  // scan sequencer: off -> guard -> on, digit stepping, boundary flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_dig   <= '0;
      r_bnd   <= 1'b0;
    end else begin
      r_bnd <= 1'b0;
      case (r_state)
        S_OFF: begin
          if (enable) begin
            r_state <= S_GUARD;
            r_cnt   <= '0;
            r_dig   <= '0;
          end
        end
        S_GUARD: begin
          if (!enable) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_dig   <= '0;
          end else if (r_cnt == GD_LAST) begin
            r_state <= S_ON;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ON: begin
          if (!enable) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_dig   <= '0;
          end else if (r_cnt == ON_LAST) begin
            r_state <= S_GUARD;
            r_cnt   <= '0;
            if (r_dig == DIG_LAST) begin
              r_dig <= '0;
              r_bnd <= 1'b1;
            end else begin
              r_dig <= r_dig + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_OFF;
          r_cnt   <= '0;
          r_dig   <= '0;
        end
      endcase
    end
  end

  // shadow/pending buffers; commit uses pending as held before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_pd_val  <= '0;
      r_pd_dp   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_ld_off) begin
        r_sh_val <= valor_in;
        r_sh_dp  <= dp_in;
      end else if (w_boundary && r_pending) begin
        r_sh_val <= r_pd_val;
        r_sh_dp  <= r_pd_dp;
      end
      if (w_ld_scan) begin
        r_pd_val  <= valor_in;
        r_pd_dp   <= dp_in;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // registered pin drivers, one cycle behind the sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anodos     <= AN_OFF;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
      r_pend_o     <= 1'b0;
    end else begin
      r_anodos     <= w_lit ? w_an_on : AN_OFF;
      r_seg        <= w_lit ? (w_code & {7'h7F, ~w_dp}) : SEG_BLANK;
      r_frame_done <= r_bnd;
      r_pend_o     <= r_pending;
    end
  end

  assign anodos     = r_anodos;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;
  assign pending    = r_pend_o;

endmodule

// File: tb/tb_control_display_7seg.sv
// Directed bench for control_display_7seg with REFRESH_DIV=4, GUARD_CYC=1.
// Table of per-cycle vectors plus hand sequences for corner cases.
module tb_control_display_7seg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] valor_in;
  logic [3:0]  dp_in;
  logic [3:0]  anodos;
  logic [7:0]  seg;
  logic        frame_done;
  logic        pending;

  always #5 clk = ~clk;

  control_display_7seg #(
    .N_DIG       (4),
    .REFRESH_DIV (4),
    .GUARD_CYC   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .valor_in   (valor_in),
    .dp_in      (dp_in),
    .anodos     (anodos),
    .seg        (seg),
    .frame_done (frame_done),
    .pending    (pending)
  );

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [7:0]  sg;
    logic        fd;
    logic        pd;
  } vec_t;

  localparam logic [7:0] EXP [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,
    8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'hFF, 8'hFF,
    8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  localparam logic [13:0] DARK = {4'hF, 8'hFF, 1'b0, 1'b0};

  vec_t tv [62];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [13:0] obs();
    return {anodos, seg, frame_done, pending};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [13:0] got,
                     input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: an/seg/fd/pd got %b %b %b %b want %b %b %b %b",
               nm, idx, got[13:10], got[9:2], got[1], got[0],
               exp[13:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic wait_an(input logic [3:0] tgt, input string nm);
    int k = 0;
    while (anodos !== tgt && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (anodos !== tgt) begin
      n_err++;
      $display("FAIL %s: anodos %b never reached %b", nm, anodos, tgt);
    end
  endtask

  task automatic fill();
    logic [15:0] v;
    int slot, pos, k;
    tv[0] = '{en:1'b0, ld:1'b1, val:16'h1234, dp:4'h0,
              an:4'hF, sg:8'hFF, fd:1'b0, pd:1'b0};
    tv[1] = '{en:1'b1, ld:1'b0, val:16'h0000, dp:4'h0,
              an:4'hF, sg:8'hFF, fd:1'b0, pd:1'b0};
    for (int f = 0; f < 3; f++) begin
      v = (f < 2) ? 16'h1234 : 16'h5678;
      for (int i = 0; i < 20; i++) begin
        k    = 2 + f * 20 + i;
        slot = i / 5;
        pos  = i % 5;
        tv[k].en  = 1'b1;
        tv[k].ld  = (f == 1 && i == 7);
        tv[k].val = 16'h5678;
        tv[k].dp  = 4'h0;
        tv[k].an  = (pos == 0) ? 4'hF : ~(4'b0001 << slot);
        tv[k].sg  = (pos == 0) ? 8'hFF : EXP[4'(v >> (4 * slot))];
        tv[k].fd  = (pos == 0 && slot == 0 && f > 0);
        tv[k].pd  = (f == 1 && i >= 8);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    load     = 1'b0;
    valor_in = '0;
    dp_in    = '0;
    fill();

    @(negedge clk);
    chk("reset", 0, obs(), DARK);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle", i, obs(), DARK);
    end

    for (int k = 0; k < 62; k++) begin
      enable   = tv[k].en;
      load     = tv[k].ld;
      valor_in = tv[k].val;
      dp_in    = tv[k].dp;
      @(negedge clk);
      chk("vec", k, obs(), {tv[k].an, tv[k].sg, tv[k].fd, tv[k].pd});
    end
    load = 1'b0;

    wait_an(4'b1011, "wait_dig2");
    enable = 1'b0;
    @(negedge clk);
    chk("drop", 0, obs(), DARK);
    @(negedge clk);
    chk("drop", 1, obs(), DARK);

    load     = 1'b1;
    valor_in = 16'h00B0;
    dp_in    = 4'b0001;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("reen_dark", 0, obs(), DARK);
    @(negedge clk);
    chk("reen_dark", 1, obs(), DARK);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dig0_dp", i, obs(), {4'b1110, 8'b00000010, 1'b0, 1'b0});
    end
    @(negedge clk);
    chk("guard", 0, obs(), DARK);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dig1_blank", i, obs(), {4'b1101, 8'hFF, 1'b0, 1'b0});
    end

    wait_an(4'b0111, "wait_dig3");
    load     = 1'b1;
    valor_in = 16'h1111;
    dp_in    = 4'h0;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    load     = 1'b1;
    valor_in = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("bnd_ld", 0, obs(), {4'hF, 8'hFF, 1'b1, 1'b1});
    @(negedge clk);
    chk("bnd_ld", 1, obs(), {4'b1110, 8'h9F, 1'b0, 1'b1});
    repeat (18) @(negedge clk);
    @(negedge clk);
    chk("bnd_ld", 2, obs(), {4'hF, 8'hFF, 1'b1, 1'b0});
    @(negedge clk);
    chk("bnd_ld", 3, obs(), {4'b1110, 8'h25, 1'b0, 1'b0});

    load     = 1'b1;
    valor_in = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pend_set", 0, {13'b0, pending}, 14'd1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst", 0, obs(), DARK);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst", i, obs(), DARK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
